// File: rtl/mlp_inference_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_inference_sequencer
//
// Purpose:
//   Sequences one MLP inference pass.
//   1. It streams the host's input features into layer 0 of neuron memory.
//   2. It raises run to the control unit and waits for mlp_done.
//   3. It lets the final output-neuron write drain.
//   4. It reads the output neuron and presents it on a valid/ready port.
//   The sequencer owns the neuron memory port in every phase except RUN.
//
// Optional feature (compile-time macro MLP_SEQ_WATCHDOG_EN):
//   When the macro is defined, a RUN-phase watchdog aborts the pass if
//   mlp_done does not arrive within WDOG_CYC cycles. The abort sets the
//   sticky error flag. When the macro is undefined, RUN waits indefinitely
//   and error is always 0.
//
// Ports:
//   clk, reset          clock (posedge); synchronous active-high reset
//   start, busy         host handshake; start is sampled in IDLE only
//   in_valid/in_ready   input feature stream (in_ready is high in LOAD only)
//   in_data             input feature word
//   nmem_we/addr/wdata  neuron memory write port (registered)
//   nmem_rdata          neuron memory read data, 1-cycle latency
//   run, mlp_done       control unit handshake
//   result_valid/ready  output neuron result handshake
//   result_data         output neuron value
//   error               watchdog timeout flag (sticky)
// ---------------------------------------------------------------------------
module mlp_inference_sequencer #(
  parameter int DATA_W    = 16,
  parameter int N_INPUTS  = 4,
  parameter int OUT_LAYER = 3,
  parameter int DRAIN_CYC = 2,
  parameter int WDOG_CYC  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              nmem_we,
  output logic [11:0]       nmem_addr,
  output logic [DATA_W-1:0] nmem_wdata,
  input  logic [DATA_W-1:0] nmem_rdata,
  output logic              run,
  input  logic              mlp_done,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_READ, S_CAPTURE, S_HOLD
  } state_e;

  localparam int              DRAIN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [9:0]      IDX_LAST   = 10'(N_INPUTS - 1);
  // Output neuron lives at neuron 0 of layer OUT_LAYER: {layer, 6'b0, 4'b0}.
  localparam logic [11:0]     READ_ADDR  = {2'(OUT_LAYER), 10'd0};

  state_e               state_q, state_d;
  logic [9:0]           idx_q, idx_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;

  logic                 nmem_we_q, nmem_we_d;
  logic [11:0]          nmem_addr_q, nmem_addr_d;
  logic [DATA_W-1:0]    nmem_wdata_q, nmem_wdata_d;
  logic                 run_q, run_d;
  logic                 result_valid_q, result_valid_d;
  logic [DATA_W-1:0]    result_data_q, result_data_d;
  logic                 error_q, error_d;

  logic                 transfer;

`ifdef MLP_SEQ_WATCHDOG_EN
  localparam int             WDOG_W    = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic                 timeout;

  // The counter holds the number of completed RUN cycles. mlp_done on the
  // timeout cycle takes priority, so that pass completes normally.
  assign timeout = (state_q == S_RUN) && !mlp_done && (wdog_q == WDOG_LAST);
`else
  logic                 unused_wdog;
  assign unused_wdog = ^32'(WDOG_CYC);
`endif

  assign transfer = (state_q == S_LOAD) && in_valid;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      drain_q        <= '0;
      nmem_we_q      <= 1'b0;
      nmem_addr_q    <= '0;
      nmem_wdata_q   <= '0;
      run_q          <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      error_q        <= 1'b0;
`ifdef MLP_SEQ_WATCHDOG_EN
      wdog_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      drain_q        <= drain_d;
      nmem_we_q      <= nmem_we_d;
      nmem_addr_q    <= nmem_addr_d;
      nmem_wdata_q   <= nmem_wdata_d;
      run_q          <= run_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      error_q        <= error_d;
`ifdef MLP_SEQ_WATCHDOG_EN
      wdog_q         <= wdog_d;
`endif
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
`ifdef MLP_SEQ_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (transfer) begin
          idx_d = idx_q + 10'd1;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
`ifdef MLP_SEQ_WATCHDOG_EN
            wdog_d  = '0;
`endif
          end
        end
      end
      S_RUN: begin
        if (mlp_done) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
`ifdef MLP_SEQ_WATCHDOG_EN
        else if (timeout) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_READ;
        else                       drain_d = drain_q + 1'b1;
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD: begin
        if (result_valid_q && result_ready) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    nmem_we_d      = transfer;
    nmem_addr_d    = nmem_addr_q;
    nmem_wdata_d   = nmem_wdata_q;
    if (transfer) begin
      nmem_addr_d  = {2'b00, idx_q};
      nmem_wdata_d = in_data;
    end else if (state_d == S_READ) begin
      nmem_addr_d  = READ_ADDR;
    end
    // The outputs are registered from state_d. This aligns each output with
    // the state the FSM enters on the same edge.
    run_d          = (state_d == S_RUN);
    result_valid_d = (state_d == S_HOLD);
    // nmem_rdata answers the READ-cycle address during CAPTURE.
    result_data_d  = (state_q == S_CAPTURE) ? nmem_rdata : result_data_q;
`ifdef MLP_SEQ_WATCHDOG_EN
    error_d = error_q;
    if ((state_q == S_IDLE) && start) error_d = 1'b0;
    else if (timeout)                 error_d = 1'b1;
`else
    error_d = 1'b0;
`endif
  end

  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_LOAD);
  assign nmem_we      = nmem_we_q;
  assign nmem_addr    = nmem_addr_q;
  assign nmem_wdata   = nmem_wdata_q;
  assign run          = run_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign error        = error_q;

endmodule
